// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and address-field width helpers for the
// write-back data cache.
//   state_t          - controller FSM states
//   word_w(lw)       - bits selecting a 64-bit word within a line
//   idx_w(ns)        - bits selecting a set
//   tag_w(ns, lw)    - remaining upper address bits forming the tag
//   cnt_w(lw)        - width of the beat counter / word select (at least 1)
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WB,
        ST_RREQ,
        ST_REFILL
    } state_t;

    function automatic int unsigned word_w(input int unsigned lw);
        return $clog2(lw);
    endfunction

    function automatic int unsigned idx_w(input int unsigned ns);
        return $clog2(ns);
    endfunction

    function automatic int unsigned tag_w(input int unsigned ns, input int unsigned lw);
        return 64 - 3 - word_w(lw) - idx_w(ns);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned lw);
        return (lw > 1) ? $clog2(lw) : 1;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag and data storage for the direct-mapped cache.
// Asynchronous read, synchronous write, no reset (contents are only
// meaningful when the matching valid flop in dcache_wb is set).
//   i_clk              clock
//   i_idx              set index used by both reads and writes
//   i_word_a/o_data_a  word read port for CPU lookups
//   i_word_b/o_data_b  word read port for write-back beats
//   o_tag              stored tag of set i_idx
//   i_we,i_wword,i_be,i_wdata   word write with per-byte enables
//   i_tag_we,i_tag     tag write
module dcache_array
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_SETS   = 64,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                                      i_clk,
    input  logic [idx_w(NUM_SETS)-1:0]                i_idx,
    input  logic [cnt_w(LINE_WORDS)-1:0]              i_word_a,
    output logic [63:0]                               o_data_a,
    input  logic [cnt_w(LINE_WORDS)-1:0]              i_word_b,
    output logic [63:0]                               o_data_b,
    output logic [tag_w(NUM_SETS, LINE_WORDS)-1:0]    o_tag,
    input  logic                                      i_we,
    input  logic [cnt_w(LINE_WORDS)-1:0]              i_wword,
    input  logic [7:0]                                i_be,
    input  logic [63:0]                               i_wdata,
    input  logic                                      i_tag_we,
    input  logic [tag_w(NUM_SETS, LINE_WORDS)-1:0]    i_tag
);

    localparam int unsigned TW = tag_w(NUM_SETS, LINE_WORDS);

    logic [63:0]   r_data [NUM_SETS][LINE_WORDS];
    logic [TW-1:0] r_tag  [NUM_SETS];

    assign o_data_a = r_data[i_idx][i_word_a];
    assign o_data_b = r_data[i_idx][i_word_b];
    assign o_tag    = r_tag[i_idx];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (i_be[b]) begin
                    r_data[i_idx][i_wword][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        if (i_tag_we) begin
            r_tag[i_idx] <= i_tag;
        end
    end

endmodule

// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped, write-back, write-allocate data cache.
//   clk, rst                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata/sel  core request (held stable while stalled)
//   cpu_rdata, cpu_stall     combinational load data and stall
//   mem_req/we/addr/wdata    burst request to the bus (write-back or refill)
//   mem_ready                bus accepts request / current write beat
//   mem_rvalid, mem_rdata    refill beats, ascending word order
module dcache_wb
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_SETS   = 64,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [63:0] cpu_addr,
    input  logic [63:0] cpu_wdata,
    input  logic [7:0]  cpu_sel,
    output logic [63:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata
);

    localparam int unsigned OW = word_w(LINE_WORDS);
    localparam int unsigned IW = idx_w(NUM_SETS);
    localparam int unsigned TW = tag_w(NUM_SETS, LINE_WORDS);
    localparam int unsigned CW = cnt_w(LINE_WORDS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);

    state_t              r_state, w_state_nxt;
    logic [CW-1:0]       r_beat;
    logic [NUM_SETS-1:0] r_valid;
    logic [NUM_SETS-1:0] r_dirty;

    logic [IW-1:0] w_idx;
    logic [TW-1:0] w_tag, w_rd_tag;
    logic [CW-1:0] w_word;
    logic [63:0]   w_rd_word, w_vic_word;
    logic          w_hit, w_nop, w_miss, w_store, w_last, w_wb_acc, w_rf_beat;
    logic          w_unused_bits;

    assign w_unused_bits = ^cpu_addr[2:0];
    assign w_idx = cpu_addr[3+OW +: IW];
    assign w_tag = cpu_addr[63 -: TW];

    generate
        if (OW == 0) begin : g_one_word
            assign w_word = '0;
        end else begin : g_multi_word
            assign w_word = cpu_addr[3 +: OW];
        end
    endgenerate

    assign w_hit     = (r_state == ST_IDLE) & cpu_req & r_valid[w_idx] & (w_rd_tag == w_tag);
    assign w_nop     = cpu_we & (cpu_sel == '0);
    assign w_miss    = (r_state == ST_IDLE) & cpu_req & ~w_hit & ~w_nop;
    assign w_store   = w_hit & cpu_we & (cpu_sel != '0);
    assign w_last    = (r_beat == LAST_BEAT);
    assign w_wb_acc  = (r_state == ST_WB) & mem_ready;
    assign w_rf_beat = (r_state == ST_REFILL) & mem_rvalid;

    assign cpu_stall = cpu_req & ~(w_hit | w_nop);
    assign cpu_rdata = w_rd_word;

    // Victim and requested line share the index because the core holds
    // cpu_addr for the whole miss sequence.
    dcache_array #(
        .NUM_SETS  (NUM_SETS),
        .LINE_WORDS(LINE_WORDS)
    ) u_array (
        .i_clk   (clk),
        .i_idx   (w_idx),
        .i_word_a(w_word),
        .o_data_a(w_rd_word),
        .i_word_b(r_beat),
        .o_data_b(w_vic_word),
        .o_tag   (w_rd_tag),
        .i_we    (w_rf_beat | w_store),
        .i_wword (w_rf_beat ? r_beat : w_word),
        .i_be    (w_rf_beat ? 8'hFF : (w_store ? cpu_sel : 8'h00)),
        .i_wdata (w_rf_beat ? mem_rdata : cpu_wdata),
        .i_tag_we(w_rf_beat & w_last),
        .i_tag   (w_tag)
    );

    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_miss) begin
                    w_state_nxt = (r_valid[w_idx] & r_dirty[w_idx]) ? ST_WB : ST_RREQ;
                end
            end
            ST_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {w_rd_tag, w_idx, {(3+OW){1'b0}}};
                mem_wdata = w_vic_word;
                if (mem_ready && w_last) begin
                    w_state_nxt = ST_RREQ;
                end
            end
            ST_RREQ: begin
                mem_req  = 1'b1;
                mem_addr = {w_tag, w_idx, {(3+OW){1'b0}}};
                if (mem_ready) begin
                    w_state_nxt = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (mem_rvalid && w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wb_acc || w_rf_beat) begin
                r_beat <= w_last ? '0 : r_beat + CW'(1);
            end
            if (w_store) begin
                r_dirty[w_idx] <= 1'b1;
            end
            if (w_wb_acc && w_last) begin
                r_dirty[w_idx] <= 1'b0;
            end
            // Line is invalid from refill request until its last beat lands,
            // so an abandoned refill never leaves a half-written line visible.
            if (r_state != ST_RREQ && w_state_nxt == ST_RREQ) begin
                r_valid[w_idx] <= 1'b0;
            end
            if (w_rf_beat && w_last) begin
                r_valid[w_idx] <= 1'b1;
                r_dirty[w_idx] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: self-checking bench for dcache_wb (NUM_SETS=64, LINE_WORDS=4).
// Two memory images are kept: arch_mem (what the core should observe) and
// phys_mem (what the bus holds). Loads are checked against arch_mem,
// write-back beats against arch_mem at the moment of eviction, and refills
// are served from phys_mem.
module tb_dcache_wb;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [7:0]  cpu_sel;
    logic        cpu_stall;
    logic        mem_req, mem_we, mem_ready, mem_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dcache_wb #(
        .NUM_SETS  (64),
        .LINE_WORDS(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_sel   (cpu_sel),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  sel;
        bit          stall;
        bit          wb;
        logic [63:0] wb_addr;
        bit          rf;
        logic [63:0] rf_addr;
    } vec_t;

    typedef struct {
        logic [63:0] base;
        logic [63:0] data;
    } beat_t;

    beat_t       q_wb[$];
    logic [63:0] q_rf[$];
    logic [63:0] q_rd[$];
    logic [63:0] arch_mem[logic [63:0]];
    logic [63:0] phys_mem[logic [63:0]];
    vec_t        tbl[12];
    int          n_vec = 0;
    int          n_mis = 0;

    function automatic logic [63:0] pat(input logic [63:0] a);
        return {a[31:0] ^ 32'h5A5A0F0F, ~a[31:0]};
    endfunction

    function automatic logic [63:0] arch_get(input logic [63:0] a);
        return arch_mem.exists(a) ? arch_mem[a] : pat(a);
    endfunction

    function automatic logic [63:0] phys_get(input logic [63:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : pat(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one request (starting just after a rising edge) and acts as
    // the bus slave until the cache releases the stall.
    task automatic access(input vec_t v, input int hold_beat, input int abort_beat);
        logic [63:0] a, wa;
        beat_t       bt;
        bit          rf_active, done, gap_done;
        logic [63:0] rf_base;
        int          rf_beat, wb_beat, hold_left;
        rf_active = 0; done = 0; gap_done = 0;
        rf_base = '0; rf_beat = 0; wb_beat = 0; hold_left = 3;
        a = {v.addr[63:3], 3'b000};

        if (v.wb) begin
            for (int b = 0; b < LW; b++) begin
                bt.base = v.wb_addr;
                bt.data = arch_get(v.wb_addr + 64'(8*b));
                q_wb.push_back(bt);
            end
        end
        if (v.rf) q_rf.push_back(v.rf_addr);
        if (!v.we) begin
            q_rd.push_back(arch_get(a));
        end else begin
            wa = arch_get(a);
            for (int b = 0; b < 8; b++)
                if (v.sel[b]) wa[8*b +: 8] = v.wdata[8*b +: 8];
            arch_mem[a] = wa;
        end

        cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr;
        cpu_wdata = v.wdata; cpu_sel = v.sel;
        @(negedge clk);
        chk("stall_first", cpu_stall, v.stall);

        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
            if (!cpu_stall) begin
                if (!v.we && q_rd.size() > 0) chk("rdata", cpu_rdata, q_rd.pop_front());
                chk("refill_beats_seen", rf_active, 0);
                done = 1;
            end else if (mem_req && mem_we) begin
                if (q_wb.size() == 0) begin
                    n_vec++; n_mis++;
                    $display("FAIL unexpected_wb: mem_addr %h, no write-back expected", mem_addr);
                    done = 1;
                end else begin
                    chk("wb_addr", mem_addr, q_wb[0].base);
                    chk("wb_data", mem_wdata, q_wb[0].data);
                    if (wb_beat == hold_beat && hold_left > 0) begin
                        hold_left--;
                    end else begin
                        mem_ready = 1'b1;
                        phys_mem[q_wb[0].base + 64'(8*wb_beat)] = mem_wdata;
                        void'(q_wb.pop_front());
                        wb_beat++;
                    end
                end
            end else if (mem_req && !mem_we) begin
                if (q_rf.size() == 0) begin
                    n_vec++; n_mis++;
                    $display("FAIL unexpected_rreq: mem_addr %h, no refill expected", mem_addr);
                    done = 1;
                end else begin
                    chk("rreq_addr", mem_addr, q_rf[0]);
                    mem_ready = 1'b1;
                    rf_base = q_rf.pop_front();
                    rf_active = 1; rf_beat = 0;
                end
            end else if (rf_active) begin
                if (rf_beat == 2 && !gap_done) begin
                    gap_done = 1;
                end else begin
                    mem_rvalid = 1'b1;
                    mem_rdata = phys_get(rf_base + 64'(8*rf_beat));
                    if (rf_beat == abort_beat) rst = 1'b1;
                    rf_beat++;
                    if (rf_beat == LW) rf_active = 0;
                end
            end
            @(posedge clk); #1;
            if (rst) begin
                rst = 1'b0; cpu_req = 1'b0; mem_rvalid = 1'b0; mem_ready = 1'b0;
                @(negedge clk);
                chk("mem_req_after_rst", mem_req, 0);
                chk("mem_addr_after_rst", mem_addr, 0);
                q_wb.delete(); q_rf.delete(); q_rd.delete();
                @(posedge clk); #1;
                return;
            end
            if (!done) @(negedge clk);
        end
        if (!done) begin
            n_vec++; n_mis++;
            $display("FAIL timeout: addr %h still stalled", v.addr);
        end
        cpu_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        chk("wb_beats_left", q_wb.size(), 0);
        chk("rreq_left", q_rf.size(), 0);
        q_rd.delete();
    endtask

    initial begin
        vec_t h;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
        cpu_wdata = '0; cpu_sel = '0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = '0;
        arch_mem[64'h1000] = 64'h1122334455667788;
        phys_mem[64'h1000] = 64'h1122334455667788;

        //            we  addr          wdata                   sel    stall wb  wb_addr       rf  rf_addr
        tbl[0]  = '{0, 64'h1000, 64'h0,                  8'h00, 1, 0, 64'h0,    1, 64'h1000};
        tbl[1]  = '{0, 64'h1008, 64'h0,                  8'h00, 0, 0, 64'h0,    0, 64'h0};
        tbl[2]  = '{1, 64'h1000, 64'hFF,                 8'h01, 0, 0, 64'h0,    0, 64'h0};
        tbl[3]  = '{0, 64'h1000, 64'h0,                  8'h00, 0, 0, 64'h0,    0, 64'h0};
        tbl[4]  = '{0, 64'h1800, 64'h0,                  8'h00, 1, 1, 64'h1000, 1, 64'h1800};
        tbl[5]  = '{0, 64'h2000, 64'h0,                  8'h00, 1, 0, 64'h0,    1, 64'h2000};
        tbl[6]  = '{1, 64'h3018, 64'hDEADBEEFCAFEF00D,   8'hF0, 1, 0, 64'h0,    1, 64'h3000};
        tbl[7]  = '{0, 64'h3018, 64'h0,                  8'h00, 0, 0, 64'h0,    0, 64'h0};
        tbl[8]  = '{1, 64'h5000, 64'hA5A5A5A5A5A5A5A5,   8'h00, 0, 0, 64'h0,    0, 64'h0};
        tbl[9]  = '{0, 64'h5000, 64'h0,                  8'h00, 1, 1, 64'h3000, 1, 64'h5000};
        tbl[10] = '{0, 64'h1040, 64'h0,                  8'h00, 1, 0, 64'h0,    1, 64'h1040};
        tbl[11] = '{0, 64'h1000, 64'h0,                  8'h00, 1, 0, 64'h0,    1, 64'h1000};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_stall", cpu_stall, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) access(tbl[i], -1, -1);

        // Dirty the resident line, then evict it with the bus stalling beat 1.
        h = '{1, 64'h1008, 64'h0123456789ABCDEF, 8'hFF, 0, 0, 64'h0, 0, 64'h0};
        access(h, -1, -1);
        h = '{0, 64'h1800, 64'h0, 8'h00, 1, 1, 64'h1000, 1, 64'h1800};
        access(h, 1, -1);

        // Reset lands on refill beat 2; the retry must refill the whole line.
        h = '{0, 64'h2040, 64'h0, 8'h00, 1, 0, 64'h0, 1, 64'h2040};
        access(h, -1, 2);
        access(h, -1, -1);
        h = '{0, 64'h1800, 64'h0, 8'h00, 1, 0, 64'h0, 1, 64'h1800};
        access(h, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
